// File: rtl/pipeif.sv
// pipeif -- instruction-fetch stage and producer side of the IF/ID interface.
//
// Holds the PC and runs a variable-latency request/acknowledge handshake with
// instruction memory. Fetched words are registered as {dpc4, dinst} for the
// decode stage. Decode steers the next PC (pcsource with bpc/jpc/rpc) and can
// stall the stage (nostall = 0). Branches have a single delay slot.
//
// Ports:
//   clk, clrn        clock (rising edge) and asynchronous active-low reset
//   bpc, jpc, rpc    branch / jump / register-jump targets from decode
//   pcsource         next-PC select: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
//   nostall          decode accepts a new IF/ID word this cycle
//   imem_req/addr    fetch request and word-aligned address (combinational)
//   imem_ack/rdata   fetch completion and instruction word
//   dpc4, dinst      IF/ID register; dinst = 0 is a nop bubble
module pipeif #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic [1:0]  pcsource,
  input  logic        nostall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dpc4,
  output logic [31:0] dinst
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] dinst_q, dinst_d;

  logic [31:0] pc4;
  logic [31:0] npc;
  logic [31:0] next_pc;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    npc = pc4;
    case (pcsource)
      2'b00:   npc = pc4;
      2'b01:   npc = bpc;
      2'b10:   npc = rpc;
      default: npc = jpc;
    endcase
  end

  // A redirect captured during a bubble outranks whatever decode drives now.
  assign next_pc = redir_valid_q ? redir_pc_q : npc;

  // The request is gated by clrn so it drops the moment reset asserts.
  assign imem_req  = clrn && (state_q == FETCH);
  assign imem_addr = pc_q;
  assign dpc4      = dpc4_q;
  assign dinst     = dinst_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_inst_d   = hold_inst_q;
    hold_pc4_d    = hold_pc4_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    dpc4_d        = dpc4_q;
    dinst_d       = dinst_q;

    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          if (nostall) begin
            dpc4_d        = pc4;
            dinst_d       = imem_rdata;
            pc_d          = next_pc;
            redir_valid_d = 1'b0;
          end else begin
            // Decode is stalled: park the word until it is accepted.
            hold_inst_d = imem_rdata;
            hold_pc4_d  = pc4;
            state_d     = HOLD;
          end
        end else if (nostall) begin
          // Bubble. A branch leaving decode now would be lost, so its target
          // is kept for the delay-slot fetch still in flight.
          dinst_d = 32'd0;
          if ((pcsource != 2'b00) && !redir_valid_q) begin
            redir_valid_d = 1'b1;
            redir_pc_d    = npc;
          end
        end
      end
      HOLD: begin
        if (nostall) begin
          dpc4_d        = hold_pc4_q;
          dinst_d       = hold_inst_q;
          pc_d          = next_pc;
          redir_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      hold_inst_q   <= 32'd0;
      hold_pc4_q    <= 32'd0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      dpc4_q        <= 32'd0;
      dinst_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc4_q    <= hold_pc4_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      dpc4_q        <= dpc4_d;
      dinst_q       <= dinst_d;
    end
  end

endmodule

// File: tb/tb_pipeif.sv
// tb_pipeif -- directed bench for the pipeif fetch stage.
// Memory model returns addr | 1 as the instruction word.
module tb_pipeif;

  logic        clk;
  logic        clrn;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] rpc;
  logic [1:0]  pcsource;
  logic        nostall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] dpc4;
  logic [31:0] dinst;

  int checks = 0;
  int errors = 0;

  pipeif #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .bpc        (bpc),
    .jpc        (jpc),
    .rpc        (rpc),
    .pcsource   (pcsource),
    .nostall    (nostall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dpc4       (dpc4),
    .dinst      (dinst)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: each word is its own address with bit 0 set.
  assign imem_rdata = imem_addr | 32'h1;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn     = 1'b0;
    bpc      = 32'd0;
    jpc      = 32'd0;
    rpc      = 32'd0;
    pcsource = 2'b00;
    nostall  = 1'b1;
    imem_ack = 1'b1;

    // Reset held across an edge
    applyStimulus();
    checkOutput("rst_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("rst_dinst", dinst, 32'd0);
    checkOutput("rst_dpc4",  dpc4, 32'd0);

    // Release between edges: first request at RESET_PC
    clrn = 1'b1;
    #1;
    checkOutput("post_rst_req",  {31'd0, imem_req}, 32'd1);
    checkOutput("post_rst_addr", imem_addr, 32'h0);

    // Zero-wait stream
    applyStimulus();
    checkOutput("s1_dpc4",  dpc4,  32'h4);
    checkOutput("s1_dinst", dinst, 32'h1);
    applyStimulus();
    checkOutput("s2_dpc4",  dpc4,  32'h8);
    checkOutput("s2_dinst", dinst, 32'h5);
    applyStimulus();
    checkOutput("s3_dpc4",  dpc4,  32'hC);
    checkOutput("s3_dinst", dinst, 32'h9);
    checkOutput("s3_addr",  imem_addr, 32'hC);

    // Branch in decode: delay slot at 0xC issues, then target 0x100
    pcsource = 2'b01;
    bpc      = 32'h100;
    applyStimulus();
    pcsource = 2'b00;
    checkOutput("br_slot_dinst", dinst, 32'hD);
    checkOutput("br_slot_dpc4",  dpc4,  32'h10);
    checkOutput("br_addr",       imem_addr, 32'h100);
    applyStimulus();
    checkOutput("br_tgt_dpc4",  dpc4,  32'h104);
    checkOutput("br_tgt_dinst", dinst, 32'h101);

    // Jump back to 0x8 so that 0xC is fetched again
    pcsource = 2'b11;
    jpc      = 32'h8;
    applyStimulus();
    pcsource = 2'b00;
    checkOutput("j8_dinst", dinst, 32'h105);
    applyStimulus();
    checkOutput("j8_tgt_dinst", dinst, 32'h9);
    checkOutput("j8_addr",      imem_addr, 32'hC);

    // Slow ack at 0xC with a jump leaving decode in the first wait cycle
    imem_ack = 1'b0;
    pcsource = 2'b11;
    jpc      = 32'h200;
    applyStimulus();
    pcsource = 2'b00;
    checkOutput("w1_dinst", dinst, 32'h0);
    checkOutput("w1_dpc4",  dpc4,  32'hC);
    checkOutput("w1_addr",  imem_addr, 32'hC);
    checkOutput("w1_req",   {31'd0, imem_req}, 32'd1);
    applyStimulus();
    checkOutput("w2_dinst", dinst, 32'h0);
    checkOutput("w2_addr",  imem_addr, 32'hC);
    applyStimulus();
    checkOutput("w3_dinst", dinst, 32'h0);
    imem_ack = 1'b1;
    applyStimulus();
    checkOutput("w_slot_dinst", dinst, 32'hD);
    checkOutput("w_slot_dpc4",  dpc4,  32'h10);
    checkOutput("w_redir_addr", imem_addr, 32'h200);

    // Jump to 0xC so the next fetch is at 0x10
    pcsource = 2'b11;
    jpc      = 32'hC;
    applyStimulus();
    pcsource = 2'b00;
    checkOutput("jc_dinst", dinst, 32'h201);
    applyStimulus();
    checkOutput("jc_tgt_dinst", dinst, 32'hD);
    checkOutput("jc_addr",      imem_addr, 32'h10);

    // Stall for two cycles while 0x10 acks
    nostall = 1'b0;
    applyStimulus();
    checkOutput("st1_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("st1_dinst", dinst, 32'hD);
    checkOutput("st1_dpc4",  dpc4,  32'h10);
    applyStimulus();
    checkOutput("st2_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("st2_dinst", dinst, 32'hD);
    nostall = 1'b1;
    applyStimulus();
    checkOutput("rel_dpc4",  dpc4,  32'h14);
    checkOutput("rel_dinst", dinst, 32'h11);
    checkOutput("rel_req",   {31'd0, imem_req}, 32'd1);
    checkOutput("rel_addr",  imem_addr, 32'h14);

    // Register jump to 0x3C
    pcsource = 2'b10;
    rpc      = 32'h3C;
    applyStimulus();
    pcsource = 2'b00;
    checkOutput("jr_dinst", dinst, 32'h15);
    checkOutput("jr_addr",  imem_addr, 32'h3C);

    // Jump to the top word and wrap
    pcsource = 2'b11;
    jpc      = 32'hFFFF_FFFC;
    applyStimulus();
    pcsource = 2'b00;
    checkOutput("top_dinst", dinst, 32'h3D);
    checkOutput("top_addr",  imem_addr, 32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_dpc4",  dpc4,  32'h0);
    checkOutput("wrap_dinst", dinst, 32'hFFFF_FFFD);
    checkOutput("wrap_addr",  imem_addr, 32'h0);

    // Jump to 0x40, then reset while its fetch waits
    pcsource = 2'b11;
    jpc      = 32'h40;
    applyStimulus();
    pcsource = 2'b00;
    imem_ack = 1'b0;
    checkOutput("j40_addr", imem_addr, 32'h40);
    applyStimulus();
    checkOutput("j40_wait_dinst", dinst, 32'h0);
    #2;
    clrn = 1'b0;
    #1;
    checkOutput("ar_req",   {31'd0, imem_req}, 32'd0);
    checkOutput("ar_dinst", dinst, 32'h0);
    checkOutput("ar_dpc4",  dpc4,  32'h0);
    checkOutput("ar_addr",  imem_addr, 32'h0);
    applyStimulus();
    clrn     = 1'b1;
    imem_ack = 1'b1;
    #1;
    checkOutput("ar_rel_req",  {31'd0, imem_req}, 32'd1);
    checkOutput("ar_rel_addr", imem_addr, 32'h0);
    applyStimulus();
    checkOutput("ar_s1_dpc4",  dpc4,  32'h4);
    checkOutput("ar_s1_dinst", dinst, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeif.md
# pipeif

Instruction-fetch stage of the five-stage pipelined CPU and the producer side of the IF/ID interface consumed by the decode stage. It holds the PC and drives a variable-latency instruction-memory handshake. It registers `{dpc4, dinst}` for decode and applies decode's redirect (`pcsource`, `bpc`, `jpc`, `rpc`) and stall (`nostall`) controls. Branches have one delay slot: the instruction fetched after a branch always issues.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `clrn`  in  1: reset, asynchronous, active-low.
- `bpc`  in  32: branch target from decode.
- `jpc`  in  32: jump target from decode.
- `rpc`  in  32: register jump target (jr) from decode, already forwarded.
- `pcsource`  in  2: next-PC select. 00 = pc+4, 01 = bpc, 10 = rpc, 11 = jpc.
- `nostall`  in  1: 1 = decode accepts a new IF/ID word this cycle.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address; word-aligned.
- `imem_ack`  in  1: fetch complete; sampled only while `imem_req`=1.
- `imem_rdata`  in  32: instruction; valid when `imem_ack`=1.
- `dpc4`  out  32: IF/ID register; PC+4 of the instruction in `dinst`.
- `dinst`  out  32: IF/ID register; instruction to decode. 0 = nop bubble.

## Operation
- State: `pc`[32], FSM {FETCH, HOLD}, `hold_inst`/`hold_pc4`[32 each], `redir_valid`, `redir_pc`[32].
- `pc4` = `pc` + 32'd4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- `npc` is the `pcsource` mux output.
- `avail` = (FETCH & `imem_ack`) | HOLD. This means an instruction is ready for IF/ID this cycle.
- Next-PC rule when an instruction is delivered: `redir_valid` ? `redir_pc` : `npc`. Deliver clears `redir_valid`.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`. Both stay stable until ack.
  - With ack and `nostall`=1: IF/ID <= {`pc4`, `imem_rdata`}; `pc` <= next-PC; stay in FETCH.
  - With ack and `nostall`=0: `hold_inst` <= `imem_rdata`; `hold_pc4` <= `pc4`; go to HOLD; `pc` unchanged.
- HOLD:
  - `imem_req`=0.
  - With `nostall`=1: IF/ID <= {`hold_pc4`, `hold_inst`}; `pc` <= next-PC; go to FETCH.
  - With `nostall`=0: hold all state.
- Bubble: `nostall`=1 and `avail`=0.
  - `dinst` <= 0; `dpc4` unchanged.
  - If `pcsource`!=00: `redir_valid` <= 1; `redir_pc` <= `npc`. The redirect of a branch leaving decode is kept for the delay-slot fetch still in flight.
- `nostall`=0: IF/ID holds its value, whatever else happens.
- `redir_valid`=1 and a new nonzero `pcsource` in the same cycle: cannot occur while a bubble is in decode (bubble decodes to 00). If it does occur, the latched `redir_pc` takes priority.

## Timing
- Reset values: `pc`=`RESET_PC`, FSM=FETCH, `dinst`=0, `dpc4`=0, `redir_valid`=0, `hold_*`=0, `imem_req`=0 while `clrn`=0.
- After `clrn` rises, `imem_req`=1 and `imem_addr`=`RESET_PC` in the first cycle.
- `imem_req`/`imem_addr` are combinational from state. `npc`, `bpc`, `jpc`, `rpc` and `pcsource` are used in the same cycle; there is no internal pipelining.
- Zero-wait memory (ack in the request cycle): one instruction per cycle. IF/ID updates on the edge after address presentation.
- Stall to resume: the held word reaches IF/ID on the first edge with `nostall`=1. The next request starts the cycle after.
- Reset mid-fetch: the request drops asynchronously and the outstanding access is abandoned. The memory must discard it.

## Test plan
- Reset and stream, `RESET_PC`=0, ack every cycle, `imem_rdata`=addr|1, `pcsource`=00.
  - During reset: `imem_req`=0, `dinst`=0.
  - After reset, consecutive edges give IF/ID = {4,1}, {8,5}, {12,9}.
- Branch with delay slot: while `dinst` is at 0x8, drive `pcsource`=01, `bpc`=0x100.
  - The delay slot at 0xC is delivered.
  - The next address is 0x100; {0x104, 0x101} follows.
- Variable latency with redirect: ack for address 0xC arrives 3 cycles late. During the first wait cycle, `pcsource`=11 and `jpc`=0x200.
  - Decode sees bubbles (`dinst`=0) during the wait.
  - 0xC is delivered, then `imem_addr`=0x200.
- Stall with early ack: `nostall`=0 for 2 cycles while ack arrives for address 0x10.
  - Enters HOLD with `imem_req`=0.
  - IF/ID holds its value.
  - On release, {0x14, data} loads and fetch resumes at 0x14.
- Register jump and wrap:
  - `pcsource`=10 with `rpc`=0x3C: the next address is 0x3C.
  - With `pc`=32'hFFFF_FFFC: `dpc4`=0 and the next address is 0.
- Asynchronous reset mid-wait at address 0x40: `imem_req` drops immediately, `dinst`=0, and after release the fetch restarts at `RESET_PC`.
